// File: rtl/ili9341_pkg.sv
// Shared ILI9341 definitions: opcodes, decoder state encoding and window payload.
// Used by both the receive sink and the transmit controller.
package ili9341_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COORD_W = 9;
    localparam int unsigned PIX_W   = 16;

    localparam logic [BYTE_W-1:0] OP_SWRESET = 8'h01;
    localparam logic [BYTE_W-1:0] OP_CASET   = 8'h2A;
    localparam logic [BYTE_W-1:0] OP_PASET   = 8'h2B;
    localparam logic [BYTE_W-1:0] OP_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_ARG,
        ST_PASET_ARG,
        ST_RAMWR,
        ST_SKIP
    } dec_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] xs;
        logic [COORD_W-1:0] xe;
        logic [COORD_W-1:0] ys;
        logic [COORD_W-1:0] ye;
    } win_t;

    // A window edge pair is usable when ordered and inside the panel.
    function automatic logic range_ok(input logic [COORD_W-1:0] s,
                                      input logic [COORD_W-1:0] e,
                                      input int unsigned        lim);
        return (s <= e) && (32'(e) < lim);
    endfunction

endpackage

// File: rtl/ili9341_spi_deser.sv
// SPI mode-0 receive front end: synchronizers, SCK rising-edge detect, byte assembly.
// Emits one byte_valid pulse per 8 bits and byte_abort when CS drops a partial byte.
module ili9341_spi_deser
    import ili9341_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    input  logic              spi_dc,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_dc,
    output logic              byte_valid,
    output logic              byte_abort
);

    logic [2:0]        sck_q, sck_d;
    logic [1:0]        mosi_q, mosi_d;
    logic [1:0]        dc_q, dc_d;
    logic [1:0]        cs_q, cs_d;
    logic              rise_q, rise_d;
    logic              bit_mosi_q, bit_mosi_d;
    logic              bit_dc_q, bit_dc_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shreg_q, shreg_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              byte_dc_q, byte_dc_d;
    logic              byte_valid_q, byte_valid_d;
    logic              abort_q, abort_d;

    always_comb begin
        sck_d        = {sck_q[1:0], spi_sck};
        mosi_d       = {mosi_q[0], spi_mosi};
        dc_d         = {dc_q[0], spi_dc};
        cs_d         = {cs_q[0], spi_cs};
        // Edge is registered with its data so the byte lands 3 clk after SCK is first seen high.
        rise_d       = sck_q[1] & ~sck_q[2] & ~cs_q[1];
        bit_mosi_d   = mosi_q[1];
        bit_dc_d     = dc_q[1];
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        byte_d       = byte_q;
        byte_dc_d    = byte_dc_q;
        byte_valid_d = 1'b0;
        abort_d      = 1'b0;
        if (rise_q) begin
            shreg_d   = {shreg_q[5:0], bit_mosi_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_d       = {shreg_q, bit_mosi_q};
                byte_dc_d    = bit_dc_q;
                byte_valid_d = 1'b1;
            end
        end else if (cs_q[1] && (bit_cnt_q != 3'd0)) begin
            bit_cnt_d = 3'd0;
            abort_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_q        <= '0;
            mosi_q       <= '0;
            dc_q         <= '0;
            cs_q         <= 2'b11;
            rise_q       <= 1'b0;
            bit_mosi_q   <= 1'b0;
            bit_dc_q     <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            byte_q       <= '0;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
            dc_q         <= dc_d;
            cs_q         <= cs_d;
            rise_q       <= rise_d;
            bit_mosi_q   <= bit_mosi_d;
            bit_dc_q     <= bit_dc_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            byte_q       <= byte_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            abort_q      <= abort_d;
        end
    end

    assign byte_data  = byte_q;
    assign byte_dc    = byte_dc_q;
    assign byte_valid = byte_valid_q;
    assign byte_abort = abort_q;

endmodule

// File: rtl/ili9341_spi_sink.sv
// ILI9341 SPI receiver model: decodes CASET/PASET/RAMWR/SWRESET and emits
// addressed RGB565 pixels, command strobes and protocol error pulses.
module ili9341_spi_sink
    import ili9341_pkg::*;
#(
    parameter int unsigned WIDTH  = 240,
    parameter int unsigned HEIGHT = 240
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               spi_cs,
    input  logic               spi_dc,
    output logic               cmd_valid,
    output logic [BYTE_W-1:0]  cmd_byte,
    output logic               pix_valid,
    output logic [PIX_W-1:0]   pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_done,
    output logic               err
);

    localparam win_t WIN_DEFAULT = '{xs: '0, xe: COORD_W'(WIDTH - 1),
                                     ys: '0, ye: COORD_W'(HEIGHT - 1)};

    logic [BYTE_W-1:0] des_byte;
    logic              des_dc;
    logic              des_valid;
    logic              des_abort;

    ili9341_spi_deser u_deser (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .spi_dc     (spi_dc),
        .byte_data  (des_byte),
        .byte_dc    (des_dc),
        .byte_valid (des_valid),
        .byte_abort (des_abort)
    );

    dec_state_e         state_q, state_d;
    win_t               win_q, win_d;
    logic [1:0]         arg_cnt_q, arg_cnt_d;
    logic [COORD_W-1:0] arg_start_q, arg_start_d;
    logic               arg_end_hi_q, arg_end_hi_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               hi_pend_q, hi_pend_d;
    logic [BYTE_W-1:0]  hi_byte_q, hi_byte_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [BYTE_W-1:0]  cmd_byte_q, cmd_byte_d;
    logic               pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0]   pix_data_q, pix_data_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    logic [COORD_W-1:0] arg_end;

    assign arg_end = {arg_end_hi_q, des_byte};

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        arg_cnt_d    = arg_cnt_q;
        arg_start_d  = arg_start_q;
        arg_end_hi_d = arg_end_hi_q;
        x_d          = x_q;
        y_d          = y_q;
        hi_pend_d    = hi_pend_q;
        hi_byte_d    = hi_byte_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_done_d = 1'b0;
        err_d        = des_abort;

        if (des_valid && !des_dc) begin
            // A command always aborts whatever transaction was in flight.
            cmd_valid_d = 1'b1;
            cmd_byte_d  = des_byte;
            if ((state_q == ST_RAMWR && hi_pend_q) ||
                state_q == ST_CASET_ARG || state_q == ST_PASET_ARG) begin
                err_d = 1'b1;
            end
            hi_pend_d = 1'b0;
            arg_cnt_d = 2'd0;
            case (des_byte)
                OP_CASET: state_d = ST_CASET_ARG;
                OP_PASET: state_d = ST_PASET_ARG;
                OP_RAMWR: begin
                    state_d = ST_RAMWR;
                    x_d     = win_q.xs;
                    y_d     = win_q.ys;
                end
                OP_SWRESET: begin
                    state_d = ST_IDLE;
                    win_d   = WIN_DEFAULT;
                end
                default: state_d = ST_SKIP;
            endcase
        end else if (des_valid) begin
            case (state_q)
                ST_CASET_ARG, ST_PASET_ARG: begin
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    case (arg_cnt_q)
                        2'd0: arg_start_d[8]   = des_byte[0];
                        2'd1: arg_start_d[7:0] = des_byte;
                        2'd2: arg_end_hi_d     = des_byte[0];
                        default: begin
                            state_d = ST_SKIP;
                            if (!range_ok(arg_start_q, arg_end,
                                          (state_q == ST_CASET_ARG) ? WIDTH : HEIGHT)) begin
                                err_d = 1'b1;
                            end else if (state_q == ST_CASET_ARG) begin
                                win_d.xs = arg_start_q;
                                win_d.xe = arg_end;
                            end else begin
                                win_d.ys = arg_start_q;
                                win_d.ye = arg_end;
                            end
                        end
                    endcase
                end
                ST_RAMWR: begin
                    if (!hi_pend_q) begin
                        hi_byte_d = des_byte;
                        hi_pend_d = 1'b1;
                    end else begin
                        hi_pend_d   = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_data_d  = {hi_byte_q, des_byte};
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        // Raster advance; last pixel of the window wraps to its origin.
                        if (x_q == win_q.xe) begin
                            x_d = win_q.xs;
                            if (y_q == win_q.ye) begin
                                y_d          = win_q.ys;
                                frame_done_d = 1'b1;
                            end else begin
                                y_d = y_q + 9'd1;
                            end
                        end else begin
                            x_d = x_q + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            win_q        <= WIN_DEFAULT;
            arg_cnt_q    <= '0;
            arg_start_q  <= '0;
            arg_end_hi_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            hi_pend_q    <= 1'b0;
            hi_byte_q    <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            arg_cnt_q    <= arg_cnt_d;
            arg_start_q  <= arg_start_d;
            arg_end_hi_q <= arg_end_hi_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hi_pend_q    <= hi_pend_d;
            hi_byte_q    <= hi_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ili9341_spi_sink.sv
// Scoreboard bench for ili9341_spi_sink: directed SPI traffic, expectations queued
// at issue time and retired by a monitor whenever the DUT strobes an output.
module tb_ili9341_spi_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_cs;
    logic        spi_dc;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_done;
    logic        err;

    always #5 clk = ~clk;

    ili9341_spi_sink #(.WIDTH(240), .HEIGHT(240)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .spi_dc     (spi_dc),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_done (frame_done),
        .err        (err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        fd;
        logic        lat;
    } pix_exp_t;

    localparam int unsigned FIFO_D = 64;

    logic [7:0] exp_cmd_fifo [FIFO_D];
    pix_exp_t   exp_pix_fifo [FIFO_D];
    int cmd_wr = 0, cmd_rd = 0, pix_wr = 0, pix_rd = 0;
    int err_exp = 0, err_seen = 0;
    int checks = 0, errors = 0;
    int cyc = 0, last_e0 = 0;
    bit tb_done = 1'b0;
    bit rst_low_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus side ----------------
    task automatic push_cmd(input logic [7:0] b);
        exp_cmd_fifo[cmd_wr % FIFO_D] = b;
        cmd_wr++;
    endtask

    task automatic push_pix(input logic [15:0] d, input int x, input int y,
                            input logic fd, input logic lat);
        pix_exp_t e;
        e.data = d; e.x = 9'(x); e.y = 9'(y); e.fd = fd; e.lat = lat;
        exp_pix_fifo[pix_wr % FIFO_D] = e;
        pix_wr++;
    endtask

    task automatic push_err();
        err_exp++;
    endtask

    // One mode-0 bit: data set while SCK low, SCK high for 3 clk, low for 4 clk.
    task automatic spi_bit(input logic b, input logic dc);
        @(negedge clk);
        spi_mosi = b;
        spi_dc   = dc;
        repeat (2) @(negedge clk);
        @(negedge clk);
        spi_sck = 1'b1;
        last_e0 = cyc + 1;
        repeat (3) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i], dc);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        push_cmd(b);
        send_byte(1'b0, b);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_byte(1'b1, b);
    endtask

    task automatic send_pix(input logic [15:0] p);
        send_data(p[15:8]);
        send_data(p[7:0]);
    endtask

    task automatic send_window(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
        send_cmd(op);
        send_data(s[15:8]);
        send_data(s[7:0]);
        send_data(e[15:8]);
        send_data(e[7:0]);
    endtask

    initial begin
        rst = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1; spi_dc = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);

        // Basic RAMWR with default window
        send_cmd(8'h2C);
        push_pix(16'hF800, 0, 0, 1'b0, 1'b0);
        push_pix(16'h07E0, 1, 0, 1'b0, 1'b0);
        send_pix(16'hF800);
        send_pix(16'h07E0);

        // 2x2 window, frame_done on 4th pixel then wrap
        send_window(8'h2A, 16'h0000, 16'h0001);
        send_window(8'h2B, 16'h0000, 16'h0001);
        send_cmd(8'h2C);
        push_pix(16'h1111, 0, 0, 1'b0, 1'b0);
        push_pix(16'h2222, 1, 0, 1'b0, 1'b0);
        push_pix(16'h3333, 0, 1, 1'b0, 1'b0);
        push_pix(16'h4444, 1, 1, 1'b1, 1'b0);
        push_pix(16'h5555, 0, 0, 1'b0, 1'b0);
        send_pix(16'h1111); send_pix(16'h2222); send_pix(16'h3333);
        send_pix(16'h4444); send_pix(16'h5555);

        // Column end == WIDTH rejected, 2x2 window kept
        push_err();
        send_window(8'h2A, 16'h0000, 16'h00F0);
        send_cmd(8'h2C);
        push_pix(16'hAABB, 0, 0, 1'b0, 1'b0);
        push_pix(16'hCCDD, 1, 0, 1'b0, 1'b0);
        push_pix(16'hEEFF, 0, 1, 1'b0, 1'b0);
        send_pix(16'hAABB); send_pix(16'hCCDD); send_pix(16'hEEFF);

        // Single-pixel window at last legal row, then SWRESET, then start>end
        send_window(8'h2A, 16'h0005, 16'h0005);
        send_window(8'h2B, 16'h00EF, 16'h00EF);
        send_cmd(8'h2C);
        push_pix(16'h9669, 5, 239, 1'b1, 1'b0);
        send_pix(16'h9669);
        send_cmd(8'h01);
        send_cmd(8'h2C);
        push_pix(16'h0102, 0, 0, 1'b0, 1'b0);
        push_pix(16'h0304, 1, 0, 1'b0, 1'b0);
        send_pix(16'h0102); send_pix(16'h0304);
        push_err();
        send_window(8'h2A, 16'h0003, 16'h0002);

        // Orphan high byte then command
        send_cmd(8'h2C);
        send_data(8'hAB);
        push_err();
        send_cmd(8'h00);

        // Incomplete CASET keeps default window
        send_cmd(8'h2A);
        send_data(8'h00);
        send_data(8'h00);
        push_err();
        send_cmd(8'h2C);
        push_pix(16'h5AA5, 0, 0, 1'b0, 1'b0);
        send_pix(16'h5AA5);

        // CS raised after 5 bits, then a clean command
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1);
        push_err();
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_cmd(8'h2A);

        // Reset in the middle of a RAMWR data byte
        push_err();
        send_cmd(8'h2C);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_cmd(8'h2C);
        push_pix(16'h1234, 0, 0, 1'b0, 1'b1);
        send_pix(16'h1234);

        repeat (20) @(negedge clk);
        tb_done = 1'b1;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rst_low_seen) begin
                chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
                chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);
                chk("rst_pix_valid", 32'(pix_valid), 32'd0);
                chk("rst_pix_data", 32'(pix_data), 32'd0);
                chk("rst_pix_x", 32'(pix_x), 32'd0);
                chk("rst_pix_y", 32'(pix_y), 32'd0);
                chk("rst_frame_done", 32'(frame_done), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
            end
            rst_low_seen = 1'b1;
        end else begin
            rst_low_seen = 1'b0;
            if (cmd_valid) begin
                if (cmd_rd >= cmd_wr) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got cmd_byte 0x%0h, expected no command", cmd_byte);
                end else begin
                    chk("cmd_byte", 32'(cmd_byte), 32'(exp_cmd_fifo[cmd_rd % FIFO_D]));
                    cmd_rd++;
                end
            end
            if (pix_valid) begin
                if (pix_rd >= pix_wr) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pix: got 0x%0h at (%0d,%0d), expected no pixel",
                             pix_data, pix_x, pix_y);
                end else begin
                    pix_exp_t e;
                    e = exp_pix_fifo[pix_rd % FIFO_D];
                    chk("pix_data", 32'(pix_data), 32'(e.data));
                    chk("pix_x", 32'(pix_x), 32'(e.x));
                    chk("pix_y", 32'(pix_y), 32'(e.y));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    if (e.lat) chk("pix_latency", 32'(cyc - last_e0), 32'd4);
                    pix_rd++;
                end
            end else if (frame_done) begin
                checks++; errors++;
                $display("FAIL frame_done_alone: got frame_done 1 without pix_valid, expected 0");
            end
            if (pix_valid && cmd_valid) begin
                checks++; errors++;
                $display("FAIL pix_cmd_overlap: got both strobes, expected at most one");
            end
            if (err) begin
                err_seen++;
                if (err_seen > err_exp) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: got err pulse %0d, expected at most %0d",
                             err_seen, err_exp);
                end
            end
        end
        if (tb_done) begin
            chk("cmd_outstanding", 32'(cmd_wr - cmd_rd), 32'd0);
            chk("pix_outstanding", 32'(pix_wr - pix_rd), 32'd0);
            chk("err_count", 32'(err_seen), 32'(err_exp));
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule

// File: doc/ili9341_spi_sink.md
ILI9341_SPI_SINK -- requirements
Module: ili9341_spi_sink

Interface
REQ-001 Parameter WIDTH, default 240, column count; default column end is WIDTH-1.
REQ-002 Parameter HEIGHT, default 240, row count; default row end is HEIGHT-1.
REQ-003 clk  input  1  single system clock; all logic SHALL run on posedge clk.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_sck  input  1  SPI clock from display driver, asynchronous to clk.
REQ-006 spi_mosi  input  1  SPI data, MSB first.
REQ-007 spi_cs  input  1  chip select, active-low.
REQ-008 spi_dc  input  1  0 = command byte, 1 = data byte.
REQ-009 cmd_valid  output  1  one-cycle pulse per received command byte.
REQ-010 cmd_byte  output  8  last command byte, held until next command.
REQ-011 pix_valid  output  1  one-cycle pulse per complete RGB565 pixel.
REQ-012 pix_data  output  16  pixel value, valid with pix_valid.
REQ-013 pix_x  output  9  column of pixel, valid with pix_valid.
REQ-014 pix_y  output  9  row of pixel, valid with pix_valid.
REQ-015 frame_done  output  1  one-cycle pulse, coincident with pix_valid of the window's last pixel.
REQ-016 err  output  1  one-cycle pulse on any protocol error (REQ-027..029).

Function
REQ-017 Inputs SHALL pass through 2-FF synchronizers; SCK rising edge detected from synchronized samples; clk SHALL be >= 4x SCK, SCK high/low each >= 2 clk periods.
REQ-018 SPI mode 0: MOSI and DC sampled on detected SCK rising edge while synchronized CS low; 8 bits form one byte, DC taken from 8th bit.
REQ-019 Byte-valid SHALL occur 3 clk after the clk edge where raw spi_sck is first sampled high for bit 0 (LSB); cmd_valid/pix_valid 1 clk after byte-valid (total latency 4 clk).
REQ-020 Decoder FSM states: IDLE, CASET_ARG, PASET_ARG, RAMWR, SKIP; any command byte SHALL exit the current state and dispatch.
REQ-021 Dispatch: 0x2A -> CASET_ARG; 0x2B -> PASET_ARG; 0x2C -> RAMWR with x<=xs, y<=ys, high-byte flag cleared; 0x01 (SWRESET) -> window reset to defaults, IDLE; other -> SKIP (data bytes discarded).
REQ-022 CASET/PASET take 4 data bytes: start[15:8], start[7:0], end[15:8], end[7:0]; window registers SHALL update only on the 4th byte; further data bytes -> SKIP.
REQ-023 Start/end values truncated to 9 bits; accepted only if start <= end and end < WIDTH (columns) / HEIGHT (rows); otherwise window unchanged, err pulse.
REQ-024 RAMWR: even data byte = pixel[15:8], odd data byte = pixel[7:0]; pix_valid on odd byte with current x,y.
REQ-025 After each pixel: x==xe -> x<=xs, y<=y+1; else x<=x+1; at x==xe and y==ye -> frame_done, x<=xs, y<=ys (wrap, stream continues).
REQ-026 Data bytes in IDLE are discarded silently.
REQ-027 CS deasserted with 1..7 bits pending: partial byte discarded, bit counter cleared, err pulse; FSM state retained.
REQ-028 Command byte arriving with RAMWR high byte pending: high byte discarded, err pulse, command dispatched normally.
REQ-029 Incomplete CASET/PASET (command before 4th byte): previous window retained, err pulse.
REQ-030 cmd_valid and err MAY assert in the same cycle; pix_valid and cmd_valid SHALL never coincide.

Reset
REQ-031 On rst low: all outputs 0, cmd_byte 0x00, FSM IDLE, bit counter 0, xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1, synchronizers to idle (CS=1, SCK=0).
REQ-032 Reset mid-byte or mid-frame SHALL discard all partial state; first byte after release SHALL be decoded from bit 7.

Structure
REQ-033 Package ili9341_pkg SHALL hold opcode constants (0x01, 0x2A, 0x2B, 0x2C) and FSM state encoding, shared with the transmit controller.
REQ-034 Sub-module ili9341_spi_deser SHALL contain synchronizers, edge detect and byte assembler, emitting byte, dc and byte-valid.

Verification
REQ-035 Reset, send cmd 0x2C then 4 bytes 0xF8,0x00,0x07,0xE0 -> two pix_valid: (0,0)=0xF800, (1,0)=0x07E0; no err.
REQ-036 CASET 0x0000..0x0001, PASET 0x0000..0x0001, RAMWR 8 bytes -> pixels at (0,0),(1,0),(0,1),(1,1); frame_done with 4th pixel.
REQ-037 CASET end 0x00F0 (240, WIDTH=240) -> err pulse; following RAMWR pixel at (0,0), window unchanged.
REQ-038 RAMWR, 1 data byte 0xAB, then cmd 0x00 -> err pulse, no pix_valid, cmd_valid with cmd_byte 0x00.
REQ-039 CS raised after 5 bits, then full byte 0x2A -> err pulse once, cmd_valid with cmd_byte 0x2A.
REQ-040 rst asserted after 3 bits of RAMWR data, released, cmd 0x2C + 0x12,0x34 -> pix_data 0x1234 at (0,0), latency 4 clk per REQ-019.
